// File: rtl/nx1_mgport_if.sv
// mem0 request-side bus of nx1_mgport: command handshake towards the memory
// controller, write-data pop and read-data push.
interface nx1_mgport_if #(
  parameter int DW = 32
);
  localparam int MW = DW / 8;

  logic          cmd_req;
  logic [2:0]    cmd_instr;
  logic [5:0]    cmd_bl;
  logic [29:0]   cmd_byte_addr;
  logic          cmd_ack;
  logic [MW-1:0] wr_mask;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          rd_req;
  logic [DW-1:0] rd_data;

  modport master (
    output cmd_req, cmd_instr, cmd_bl, cmd_byte_addr, wr_mask, wr_data,
    input  cmd_ack, wr_ack, rd_req, rd_data
  );

  modport slave (
    input  cmd_req, cmd_instr, cmd_bl, cmd_byte_addr, wr_mask, wr_data,
    output cmd_ack, wr_ack, rd_req, rd_data
  );
endinterface

// File: rtl/nx1_mgport.sv
// Single-clock port buffer that only issues memory commands which can complete
// without stalling. Define NX1_MGPORT_RDRSV_EN to gate reads on reserved read-FIFO space.
module nx1_mgport #(
  parameter int DW         = 32,
  parameter int DEPTH_LOG2 = 6,
  parameter int CMD_LOG2   = 2
) (
  input  logic                  mem_clk,
  input  logic                  mem_rst,
  input  logic                  p0_cmd_en,
  input  logic [2:0]            p0_cmd_instr,
  input  logic [5:0]            p0_cmd_bl,
  input  logic [29:0]           p0_cmd_byte_addr,
  output logic                  p0_cmd_empty,
  output logic                  p0_cmd_full,
  input  logic                  p0_wr_en,
  input  logic [DW/8-1:0]       p0_wr_mask,
  input  logic [DW-1:0]         p0_wr_data,
  output logic                  p0_wr_full,
  output logic                  p0_wr_empty,
  output logic [DEPTH_LOG2:0]   p0_wr_count,
  output logic                  p0_wr_underrun,
  output logic                  p0_wr_error,
  input  logic                  p0_rd_en,
  output logic [DW-1:0]         p0_rd_data,
  output logic                  p0_rd_full,
  output logic                  p0_rd_empty,
  output logic [DEPTH_LOG2:0]   p0_rd_count,
  output logic                  p0_rd_overflow,
  output logic                  p0_rd_error,
  nx1_mgport_if.master          mem0
);
  localparam int MW    = DW / 8;
  localparam int AW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CD    = 1 << CMD_LOG2;

  localparam logic [CMD_LOG2:0] CINC = {{CMD_LOG2{1'b0}}, 1'b1};
  localparam logic [CW-1:0]     PINC = {{AW{1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GATE = 2'd1;
  localparam logic [1:0] ST_REQ  = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [2:0]        cq_instr [CD];
  logic [5:0]        cq_bl    [CD];
  logic [29:0]       cq_addr  [CD];
  logic [CMD_LOG2:0] cwp, crp;
  logic [MW+DW-1:0]  wmem [DEPTH];
  logic [DW-1:0]     rmem [DEPTH];
  logic [CW-1:0]     wwp, wrp, rwp, rrp;
  logic [CW-1:0]     wr_commit, wr_avail, hold_words;
  logic              cmd_push, cmd_pop, wr_push, wr_pop, rd_push, rd_pop;
  logic              is_wr, is_rd, wr_ok, rd_ok, cmd_acc;

  assign p0_cmd_empty = (cwp == crp);
  assign p0_cmd_full  = (cwp[CMD_LOG2] != crp[CMD_LOG2]) &&
                        (cwp[CMD_LOG2-1:0] == crp[CMD_LOG2-1:0]);
  assign cmd_push     = p0_cmd_en && !p0_cmd_full;
  assign cmd_pop      = (state == ST_IDLE) && !p0_cmd_empty;

  // Count never exceeds depth, so its MSB alone marks a full FIFO.
  assign p0_wr_count  = wwp - wrp;
  assign p0_wr_empty  = (p0_wr_count == '0);
  assign p0_wr_full   = p0_wr_count[CW-1];
  assign wr_push      = p0_wr_en && !p0_wr_full;
  assign wr_pop       = mem0.wr_ack && !p0_wr_empty;
  assign {mem0.wr_mask, mem0.wr_data} = wmem[wrp[AW-1:0]];

  assign p0_rd_count  = rwp - rrp;
  assign p0_rd_empty  = (p0_rd_count == '0);
  assign p0_rd_full   = p0_rd_count[CW-1];
  assign rd_push      = mem0.rd_req && !p0_rd_full;
  assign rd_pop       = p0_rd_en && !p0_rd_empty;
  assign p0_rd_data   = rmem[rrp[AW-1:0]];

  always_ff @(posedge mem_clk) begin
    if (cmd_push) begin
      cq_instr[cwp[CMD_LOG2-1:0]] <= p0_cmd_instr;
      cq_bl[cwp[CMD_LOG2-1:0]]    <= p0_cmd_bl;
      cq_addr[cwp[CMD_LOG2-1:0]]  <= p0_cmd_byte_addr;
    end
    if (wr_push) wmem[wwp[AW-1:0]] <= {p0_wr_mask, p0_wr_data};
    if (rd_push) rmem[rwp[AW-1:0]] <= mem0.rd_data;
  end

  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      cwp <= '0;
      crp <= '0;
      wwp <= '0;
      wrp <= '0;
      rwp <= '0;
      rrp <= '0;
      p0_wr_error    <= 1'b0;
      p0_wr_underrun <= 1'b0;
      p0_rd_overflow <= 1'b0;
      p0_rd_error    <= 1'b0;
    end else begin
      if (cmd_push) cwp <= cwp + CINC;
      if (cmd_pop)  crp <= crp + CINC;
      if (wr_push)  wwp <= wwp + PINC;
      if (wr_pop)   wrp <= wrp + PINC;
      if (rd_push)  rwp <= rwp + PINC;
      if (rd_pop)   rrp <= rrp + PINC;
      p0_wr_error    <= p0_wr_error    | (p0_wr_en && p0_wr_full);
      p0_wr_underrun <= p0_wr_underrun | (mem0.wr_ack && p0_wr_empty);
      p0_rd_overflow <= p0_rd_overflow | (mem0.rd_req && p0_rd_full);
      p0_rd_error    <= p0_rd_error    | (p0_rd_en && p0_rd_empty);
    end
  end

  // Hold registers double as the mem0 command payload.
  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      mem0.cmd_instr     <= '0;
      mem0.cmd_bl        <= '0;
      mem0.cmd_byte_addr <= '0;
    end else if (cmd_pop) begin
      mem0.cmd_instr     <= cq_instr[crp[CMD_LOG2-1:0]];
      mem0.cmd_bl        <= cq_bl[crp[CMD_LOG2-1:0]];
      mem0.cmd_byte_addr <= cq_addr[crp[CMD_LOG2-1:0]];
    end
  end

  assign is_wr      = !mem0.cmd_instr[2] && !mem0.cmd_instr[0];
  assign is_rd      = !mem0.cmd_instr[2] &&  mem0.cmd_instr[0];
  assign hold_words = {{(CW-6){1'b0}}, mem0.cmd_bl} + PINC;
  assign cmd_acc    = (state == ST_REQ) && mem0.cmd_ack;
  assign wr_avail   = p0_wr_count - wr_commit;
  assign wr_ok      = (wr_avail >= hold_words);

  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) wr_commit <= '0;
    else wr_commit <= wr_commit + ((cmd_acc && is_wr) ? hold_words : '0)
                                - (wr_pop ? PINC : '0);
  end

`ifdef NX1_MGPORT_RDRSV_EN
  localparam logic [CW+1:0] RD_DEPTH = {2'b00, 1'b1, {AW{1'b0}}};
  logic [CW-1:0] rd_resv;
  logic [CW+1:0] rd_need;

  assign rd_need = {2'b00, p0_rd_count} + {2'b00, rd_resv} + {2'b00, hold_words};
  assign rd_ok   = (rd_need <= RD_DEPTH);

  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) rd_resv <= '0;
    else rd_resv <= rd_resv + ((cmd_acc && is_rd) ? hold_words : '0)
                            - (rd_push ? PINC : '0);
  end
`else
  assign rd_ok = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!p0_cmd_empty) state_nxt = ST_GATE;
      ST_GATE: if ((is_wr && wr_ok) || (is_rd && rd_ok) || (!is_wr && !is_rd))
                 state_nxt = ST_REQ;
      ST_REQ:  if (mem0.cmd_ack) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  assign mem0.cmd_req = (state == ST_REQ);
endmodule

// File: tb/tb_nx1_mgport.sv
// Bench for nx1_mgport: queue-based model of the data FIFOs and sticky flags,
// checked every cycle, plus literal checks of command issue timing and gating.
module tb_nx1_mgport;
  localparam int DW = 32, DL = 6, CL = 2, MW = DW / 8, DEPTH = 64;

  logic mem_clk = 1'b0, mem_rst = 1'b1;
  logic p0_cmd_en = 1'b0;
  logic [2:0] p0_cmd_instr = '0;
  logic [5:0] p0_cmd_bl = '0;
  logic [29:0] p0_cmd_byte_addr = '0;
  logic p0_cmd_empty, p0_cmd_full;
  logic p0_wr_en = 1'b0;
  logic [MW-1:0] p0_wr_mask = '0;
  logic [DW-1:0] p0_wr_data = '0;
  logic p0_wr_full, p0_wr_empty, p0_wr_underrun, p0_wr_error;
  logic [DL:0] p0_wr_count, p0_rd_count;
  logic p0_rd_en = 1'b0;
  logic [DW-1:0] p0_rd_data;
  logic p0_rd_full, p0_rd_empty, p0_rd_overflow, p0_rd_error;

  nx1_mgport_if #(.DW(DW)) m_if ();

  nx1_mgport #(.DW(DW), .DEPTH_LOG2(DL), .CMD_LOG2(CL)) dut (
    .mem_clk(mem_clk), .mem_rst(mem_rst),
    .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr), .p0_cmd_bl(p0_cmd_bl),
    .p0_cmd_byte_addr(p0_cmd_byte_addr), .p0_cmd_empty(p0_cmd_empty), .p0_cmd_full(p0_cmd_full),
    .p0_wr_en(p0_wr_en), .p0_wr_mask(p0_wr_mask), .p0_wr_data(p0_wr_data),
    .p0_wr_full(p0_wr_full), .p0_wr_empty(p0_wr_empty), .p0_wr_count(p0_wr_count),
    .p0_wr_underrun(p0_wr_underrun), .p0_wr_error(p0_wr_error),
    .p0_rd_en(p0_rd_en), .p0_rd_data(p0_rd_data), .p0_rd_full(p0_rd_full),
    .p0_rd_empty(p0_rd_empty), .p0_rd_count(p0_rd_count),
    .p0_rd_overflow(p0_rd_overflow), .p0_rd_error(p0_rd_error),
    .mem0(m_if)
  );

  always #5 mem_clk = ~mem_clk;

  int n_chk = 0, n_pass = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Behavioural model: FIFOs as queues, flags as sticky bits.
  logic [MW+DW-1:0] wq[$];
  logic [DW-1:0]    rq[$];
  bit m_wunr, m_werr, m_rovf, m_rerr;

  always @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      wq.delete(); rq.delete();
      m_wunr = 0; m_werr = 0; m_rovf = 0; m_rerr = 0;
    end else begin
      int ws, rs;
      ws = wq.size();
      rs = rq.size();
      if (m_if.wr_ack) begin
        if (ws == 0) m_wunr = 1; else void'(wq.pop_front());
      end
      if (p0_wr_en) begin
        if (ws == DEPTH) m_werr = 1; else wq.push_back({p0_wr_mask, p0_wr_data});
      end
      if (p0_rd_en) begin
        if (rs == 0) m_rerr = 1; else void'(rq.pop_front());
      end
      if (m_if.rd_req) begin
        if (rs == DEPTH) m_rovf = 1; else rq.push_back(m_if.rd_data);
      end
    end
  end

  always @(negedge mem_clk) begin
    if (chk_on) begin
      chk("wr_count", p0_wr_count, wq.size());
      chk("wr_empty", p0_wr_empty, wq.size() == 0);
      chk("wr_full", p0_wr_full, wq.size() == DEPTH);
      chk("rd_count", p0_rd_count, rq.size());
      chk("rd_empty", p0_rd_empty, rq.size() == 0);
      chk("rd_full", p0_rd_full, rq.size() == DEPTH);
      chk("wr_error", p0_wr_error, m_werr);
      chk("wr_underrun", p0_wr_underrun, m_wunr);
      chk("rd_overflow", p0_rd_overflow, m_rovf);
      chk("rd_error", p0_rd_error, m_rerr);
      if (wq.size() > 0) begin
        chk("mem0_wr_data", m_if.wr_data, wq[0][DW-1:0]);
        chk("mem0_wr_mask", m_if.wr_mask, wq[0][MW+DW-1:DW]);
      end
      if (rq.size() > 0) chk("p0_rd_data", p0_rd_data, rq[0]);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge mem_clk); #1; end
  endtask

  task automatic push_cmd(input logic [2:0] ins, input logic [5:0] bl, input logic [29:0] a);
    p0_cmd_en = 1; p0_cmd_instr = ins; p0_cmd_bl = bl; p0_cmd_byte_addr = a;
    cyc();
    p0_cmd_en = 0;
  endtask

  task automatic push_wr(input logic [DW-1:0] d, input logic [MW-1:0] m);
    p0_wr_en = 1; p0_wr_data = d; p0_wr_mask = m;
    cyc();
    p0_wr_en = 0;
  endtask

  task automatic push_rd(input logic [DW-1:0] d);
    m_if.rd_req = 1; m_if.rd_data = d;
    cyc();
    m_if.rd_req = 0;
  endtask

  task automatic pop_wr();
    m_if.wr_ack = 1; cyc(); m_if.wr_ack = 0;
  endtask

  task automatic wait_req(input int budget, input string nm);
    int k = 0;
    while (!m_if.cmd_req && k < budget) begin cyc(); k++; end
    chk({nm, "_req"}, m_if.cmd_req, 1);
  endtask

  task automatic ack();
    m_if.cmd_ack = 1; cyc(); m_if.cmd_ack = 0;
  endtask

  task automatic do_reset();
    mem_rst = 1; cyc(2); mem_rst = 0; cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] wbase, rbase;
    int pin;
    wbase = 32'hA0A0_0001;
    rbase = 32'h5EED_0000;
    m_if.cmd_ack = 0; m_if.wr_ack = 0; m_if.rd_req = 0; m_if.rd_data = '0;
    cyc(3);
    // Reset state
    chk("rst_req", m_if.cmd_req, 0);
    chk("rst_instr", m_if.cmd_instr, 0);
    chk("rst_bl", m_if.cmd_bl, 0);
    chk("rst_addr", m_if.cmd_byte_addr, 0);
    chk("rst_cmd_empty", p0_cmd_empty, 1);
    chk("rst_cmd_full", p0_cmd_full, 0);
    chk("rst_wr_empty", p0_wr_empty, 1);
    chk("rst_rd_empty", p0_rd_empty, 1);
    chk("rst_wr_count", p0_wr_count, 0);
    chk("rst_rd_count", p0_rd_count, 0);
    mem_rst = 0;
    chk_on = 1;
    cyc();

    // Refresh: req three edges after p0_cmd_en is sampled
    push_cmd(3'b100, 6'd0, 30'h155);
    chk("ref_cmd_empty_e0", p0_cmd_empty, 0);
    chk("ref_req_e0", m_if.cmd_req, 0);
    cyc();
    chk("ref_req_e1", m_if.cmd_req, 0);
    chk("ref_cmd_empty_e1", p0_cmd_empty, 1);
    cyc();
    chk("ref_req_e2", m_if.cmd_req, 1);
    chk("ref_instr", m_if.cmd_instr, 3'b100);
    chk("ref_addr", m_if.cmd_byte_addr, 30'h155);
    cyc(2);
    chk("ref_req_held", m_if.cmd_req, 1);
    ack();
    chk("ref_req_drop", m_if.cmd_req, 0);

    // Command FIFO fills behind a held request; sixth push is dropped
    for (int i = 0; i < 5; i++) push_cmd(3'b100, 6'd0, 30'(i));
    chk("cmd_full", p0_cmd_full, 1);
    push_cmd(3'b100, 6'd0, 30'd5);
    for (int i = 0; i < 5; i++) begin
      wait_req(8, "cmdq");
      chk("cmdq_addr", m_if.cmd_byte_addr, 30'(i));
      ack();
    end
    cyc(6);
    chk("cmdq_dropped_req", m_if.cmd_req, 0);
    chk("cmdq_drained", p0_cmd_empty, 1);

    // Write issues only once its whole burst is buffered
    push_wr(wbase, 4'hF);
    push_wr(wbase + 1, 4'h3);
    push_cmd(3'b000, 6'd3, 30'h100);
    cyc(6);
    chk("wr_gate_hold", m_if.cmd_req, 0);
    push_wr(wbase + 2, 4'hC);
    push_wr(wbase + 3, 4'h5);
    wait_req(4, "wr");
    chk("wr_bl", m_if.cmd_bl, 3);
    chk("wr_addr", m_if.cmd_byte_addr, 30'h100);
    ack();
    for (int i = 0; i < 4; i++) begin
      chk("wr_head_order", m_if.wr_data, wbase + DW'(i));
      pop_wr();
    end
    chk("wr_empty_after", p0_wr_empty, 1);

    // Two 32-word reads, then a single-word read
    push_cmd(3'b001, 6'd31, 30'h200);
    wait_req(6, "rd1");
    chk("rd1_bl", m_if.cmd_bl, 31);
    ack();
    push_cmd(3'b001, 6'd31, 30'h240);
    wait_req(6, "rd2");
    ack();
    push_cmd(3'b001, 6'd0, 30'h280);
`ifndef NX1_MGPORT_RDRSV_EN
    wait_req(6, "rd3");
    chk("rd3_bl", m_if.cmd_bl, 0);
    ack();
    for (int i = 0; i < 64; i++) push_rd(rbase + DW'(i));
    chk("rd_full_64", p0_rd_full, 1);
    chk("rd_count_64", p0_rd_count, 64);
    chk("rd_ovf_before", p0_rd_overflow, 0);
    push_rd(32'hDEAD_BEEF);
    chk("rd_ovf_65", p0_rd_overflow, 1);
    chk("rd_count_65", p0_rd_count, 64);
`else
    cyc(6);
    chk("rd3_gated", m_if.cmd_req, 0);
    for (int i = 0; i < 64; i++) push_rd(rbase + DW'(i));
    cyc(3);
    chk("rd3_gated_full", m_if.cmd_req, 0);
    chk("rd_count_64", p0_rd_count, 64);
    p0_rd_en = 1; cyc(); p0_rd_en = 0;
    wait_req(6, "rd3");
    ack();
    push_rd(rbase + 64);
    chk("rd_full_64", p0_rd_full, 1);
`endif
    m_if.rd_req = 1; m_if.rd_data = 32'hCAFE_0000; p0_rd_en = 1;
    cyc();
    m_if.rd_req = 0; p0_rd_en = 0;
    chk("rd_pushpop_full", p0_rd_count, 63);

    // Write overflow, underrun, read-empty error
    do_reset();
    for (int i = 0; i < 65; i++) push_wr($urandom, MW'($urandom));
    chk("wr_full_65", p0_wr_full, 1);
    chk("wr_count_65", p0_wr_count, 64);
    chk("wr_error_65", p0_wr_error, 1);
    do_reset();
    pop_wr();
    chk("wr_underrun", p0_wr_underrun, 1);
    p0_rd_en = 1; cyc(); p0_rd_en = 0;
    chk("rd_error", p0_rd_error, 1);

    // Asynchronous reset while a request is pending mid-burst
    for (int i = 0; i < 4; i++) push_wr(wbase + DW'(i), 4'hF);
    push_rd(rbase);
    push_cmd(3'b000, 6'd3, 30'h300);
    wait_req(6, "mid_wr");
    ack();
    pop_wr();
    pop_wr();
    push_cmd(3'b100, 6'd0, 30'h3FF);
    wait_req(6, "mid_ref");
    #2 mem_rst = 1;
    #1;
    chk("mid_rst_req", m_if.cmd_req, 0);
    chk("mid_rst_wr_count", p0_wr_count, 0);
    chk("mid_rst_rd_count", p0_rd_count, 0);
    chk("mid_rst_wr_empty", p0_wr_empty, 1);
    chk("mid_rst_rd_empty", p0_rd_empty, 1);
    chk("mid_rst_cmd_empty", p0_cmd_empty, 1);
    chk("mid_rst_sticky", {p0_wr_underrun, p0_wr_error, p0_rd_overflow, p0_rd_error}, 0);
    cyc(2);
    mem_rst = 0;
    cyc();

    // Random data-path traffic, alternating fill-heavy and drain-heavy phases
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 600; c++) begin
        pin = (ph % 2 == 0) ? 70 : 30;
        p0_wr_en     = ($urandom_range(0, 99) < pin);
        p0_wr_data   = $urandom;
        p0_wr_mask   = MW'($urandom);
        m_if.wr_ack  = ($urandom_range(0, 99) < 100 - pin);
        m_if.rd_req  = ($urandom_range(0, 99) < pin);
        m_if.rd_data = $urandom;
        p0_rd_en     = ($urandom_range(0, 99) < 100 - pin);
        cyc();
      end
    end
    p0_wr_en = 0; m_if.wr_ack = 0; m_if.rd_req = 0; p0_rd_en = 0;
    cyc(2);
    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/nx1_mgport.md
# nx1_mgport

Single-clock, parametrised MIG-style port buffer between one client port and the cellular-RAM/SDRAM controller's mem0 request interface. It holds command, write-data and read-data FIFOs of configurable data width and depth. Unlike the dual-clock port buffer, it issues a command to memory only when it can be completed without stalling:

- A write is issued only once its full burst is already buffered.
- A read is issued only once read-FIFO space for its full burst is reserved (macro-controlled).

## Interface
- DW, 32, data width (multiple of 8); mask width MW=DW/8
- DEPTH_LOG2, 6, write/read FIFO depth 2^DEPTH_LOG2 words; must be ≥6 so a 64-word burst fits
- CMD_LOG2, 2, command FIFO depth 2^CMD_LOG2
- mem_clk  in  1  sole clock, all logic on rising edge
- mem_rst  in  1  asynchronous, active-high reset
- p0_cmd_en / p0_cmd_instr / p0_cmd_bl / p0_cmd_byte_addr  in  1/3/6/30  command push; burst = bl+1 words
- p0_cmd_empty / p0_cmd_full  out  1/1  command FIFO flags
- p0_wr_en / p0_wr_mask / p0_wr_data  in  1/MW/DW  write-data push
- p0_wr_full / p0_wr_empty / p0_wr_count / p0_wr_underrun / p0_wr_error  out  1/1/DEPTH_LOG2+1/1/1
- p0_rd_en  in  1  read-data pop
- p0_rd_data  out  DW  show-ahead head of read FIFO
- p0_rd_full / p0_rd_empty / p0_rd_count / p0_rd_overflow / p0_rd_error  out  1/1/DEPTH_LOG2+1/1/1
- mem0_cmd_req  out  1  command valid, held until ack
- mem0_cmd_instr / mem0_cmd_bl / mem0_cmd_byte_addr  out  3/6/30  command payload, stable while req=1
- mem0_cmd_ack  in  1  one-cycle command accept
- mem0_wr_mask / mem0_wr_data  out  MW/DW  show-ahead head of write FIFO
- mem0_wr_ack  in  1  pops one write word
- mem0_rd_req / mem0_rd_data  in  1/DW  pushes one read word

## Operation
- **Instruction classes:**
  - Write: instr[2]=0 and instr[0]=0.
  - Read: instr[2]=0 and instr[0]=1.
  - Other (e.g. refresh 3'b100): ungated, no data.
- **FIFOs:** binary pointers one bit wider than the address. count = wptr−rptr; empty = count==0; full = count==depth.
- **Rejected operations:** a push into a full FIFO or a pop from an empty FIFO is ignored and the pointers do not move.
  - p0_cmd_en while full: command dropped silently.
  - p0_wr_en while full: data dropped; sets sticky p0_wr_error.
  - mem0_wr_ack while empty: sets sticky p0_wr_underrun.
  - mem0_rd_req while full: data dropped; sets sticky p0_rd_overflow.
  - p0_rd_en while empty: sets sticky p0_rd_error.
  - All sticky flags clear only on mem_rst.
- **Push and pop in the same cycle:** both are accepted if legal, and count is unchanged. Legality is judged on the registered count at the start of the cycle, so a push into a full FIFO is still rejected even with a simultaneous pop.
- **Commitment counters (DEPTH_LOG2+1 bits each):**
  - wr_commit = words owed to acked writes. +(bl+1) on ack of a write; −1 per accepted mem0_wr_ack.
  - rd_resv = words owed by acked reads. +(bl+1) on ack of a read; −1 per accepted mem0_rd_req.
  - On the same cycle, both updates apply.
- **Issue FSM:**
  - IDLE: if the command FIFO is not empty, pop the head into the hold registers and go to GATE.
  - GATE, write: go to REQ when p0_wr_count − wr_commit ≥ bl+1.
  - GATE, read: go to REQ when p0_rd_count + rd_resv + bl+1 ≤ 2^DEPTH_LOG2 (see Configuration).
  - GATE, other: go to REQ immediately.
  - REQ: mem0_cmd_req=1; on mem0_cmd_ack, update the counters and go to IDLE.
- **Command outputs:** mem0_cmd_instr/bl/byte_addr are driven from the hold registers and change only on a pop in IDLE.

## Timing
- **Reset values:**
  - FSM in IDLE; all pointers, counters and sticky flags 0.
  - mem0_cmd_req=0; mem0_cmd_* payload 0.
  - p0_cmd_empty=1, p0_wr_empty=1, p0_rd_empty=1.
  - All full flags 0; all counts 0.
  - p0_rd_data and mem0_wr_data don't-care.
- **Reset mid-operation:** mem_rst asserted mid-burst clears everything asynchronously and drops mem0_cmd_req in the same cycle. Owed data is discarded.
- **Command latency:** p0_cmd_en sampled at edge 0 gives p0_cmd_empty=0 after edge 0. The head is popped at edge 1 and GATE is evaluated in cycle 2. With the gate met, mem0_cmd_req is high from edge 2, i.e. 3 cycles after p0_cmd_en.
- **Back-to-back commands:** the minimum spacing between successive mem0_cmd_req assertions is 3 cycles (REQ→IDLE→GATE→REQ).
- **Flag update timing:** flags and counts reflect a push or pop one cycle after the enable edge.
- **Data paths:** mem0_wr_data/mask and p0_rd_data are show-ahead and valid in the cycle after the corresponding push is registered.

## Configuration
- NX1_MGPORT_RDRSV_EN:
  - Defined: reads are gated by the rd_resv space check in GATE, so p0_rd_overflow cannot occur with a compliant controller.
  - Undefined: reads pass GATE immediately, the rd_resv logic is removed, and overflow is reported only via p0_rd_overflow.
  - Write gating is always present in both builds.

## Test plan
- Write path: push write cmd bl=3 while 2 words are buffered → mem0_cmd_req stays 0; push 2 more words → req rises; after ack, 4× mem0_wr_ack pop data in push order, p0_wr_empty=1.
- Two reads bl=31, rd FIFO depth 64, NX1_MGPORT_RDRSV_EN defined → both issue; a third read bl=0 holds in GATE until p0_rd_en drains ≥1 word after all 64 arrive.
- Same read sequence with the macro undefined → third read issues; 65th mem0_rd_req sets p0_rd_overflow=1, p0_rd_count stays 64.
- Push 65 write words at DEPTH_LOG2=6 → p0_wr_full=1, p0_wr_error=1, count 64; mem0_wr_ack on empty FIFO → p0_wr_underrun=1.
- Refresh cmd (3'b100) → mem0_cmd_req exactly 3 cycles after p0_cmd_en; simultaneous push+pop on full rd FIFO → push rejected, count 63.
- Assert mem_rst while mem0_cmd_req=1 mid-burst → req 0 same cycle, all counts 0, all empty flags 1, sticky flags cleared.
